// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator. Divides the system clock down to a
//   pixel clock-enable and walks a (sx, sy) raster counter over the whole frame
//   (active area, front porch, sync, back porch). It produces data-enable,
//   hsync/vsync and one-clock line/frame strobes that are aligned with sx/sy.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   enable       in   run; low freezes all state
//   pix_ce       out  one-clock pixel tick, every CLK_DIV enabled clocks
//   sx, sy       out  raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   de           out  high inside the active area
//   hsync, vsync out  sync pulses, active level set by H_POL / V_POL
//   line_start   out  one-clock strobe after sx moves to 0
//   frame_start  out  one-clock strobe after (sx, sy) moves to (0, 0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          pix_ce,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // All raster compares are done at CW bits against pre-sized constants.
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;   // div has reached DIV_MAX since the last enabled edge
  logic [CW-1:0] sx_q, sx_d;
  logic [CW-1:0] sy_q, sy_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          advance;

  // tick_q is a registered copy of (div == DIV_MAX) that is cleared by reset,
  // so the tick stays low in reset even when CLK_DIV=1. Gating with enable
  // makes pix_ce drop in the same cycle enable falls.
  assign advance = enable & tick_q;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    div_d  = div_q;
    tick_d = tick_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;

    if (enable) begin
      div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      tick_d = (div_d == DIV_MAX);
    end

    if (advance) begin
      if (sx_q == H_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
      // Decode from the new position so de/syncs land together with sx/sy.
      de_d = (sx_d < H_ACT) && (sy_d < V_ACT);
      hs_d = ((sx_d >= HS_BEG) && (sx_d < HS_END)) ? H_POL : ~H_POL;
      vs_d = ((sy_d >= VS_BEG) && (sy_d < VS_END)) ? V_POL : ~V_POL;
      ls_d = (sx_d == '0);
      fs_d = (sx_d == '0) && (sy_d == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    // NOTE: reset parks the raster on the last pixel of the frame so the first
    // pixel tick after reset wraps cleanly to (0,0) with both strobes.
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      sx_q   <= H_LAST;
      sy_q   <= V_LAST;
      de_q   <= 1'b0;
      hs_q   <= ~H_POL;
      vs_q   <= ~V_POL;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign pix_ce      = advance;
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q & enable;
  assign frame_start = fs_q & enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Drives three generator instances (default 640x480 mode, a tiny mode with
//   CLK_DIV=1, and the default mode with inverted sync polarities) from shared
//   rst/enable. A reference model derives every output from the count of
//   pixel ticks since reset: the tick count gives a linear raster index, and
//   position, de and syncs follow from division and range tests on it.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int N = 3;

  typedef struct packed {
    int unsigned div;
    int unsigned ha, hfp, hs, hbp;
    int unsigned va, vfp, vs, vbp;
    bit          hpol, vpol;
  } mode_t;

  localparam mode_t M0 = '{div:4, ha:640, hfp:16, hs:96, hbp:48,
                           va:480, vfp:10, vs:2, vbp:33, hpol:1'b0, vpol:1'b0};
  localparam mode_t M1 = '{div:1, ha:8, hfp:2, hs:2, hbp:2,
                           va:4, vfp:1, vs:1, vbp:1, hpol:1'b0, vpol:1'b0};
  localparam mode_t M2 = '{div:4, ha:640, hfp:16, hs:96, hbp:48,
                           va:480, vfp:10, vs:2, vbp:33, hpol:1'b1, vpol:1'b1};

  function automatic mode_t mode_of(input int i);
    case (i)
      0:       return M0;
      1:       return M1;
      default: return M2;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pc   [N];
  logic [9:0] sx_w [N];
  logic [9:0] sy_w [N];
  logic       de_w [N];
  logic       hs_w [N];
  logic       vs_w [N];
  logic       ls_w [N];
  logic       fs_w [N];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(M0.div), .H_ACTIVE(M0.ha), .H_FP(M0.hfp), .H_SYNC(M0.hs), .H_BP(M0.hbp),
    .V_ACTIVE(M0.va), .V_FP(M0.vfp), .V_SYNC(M0.vs), .V_BP(M0.vbp),
    .H_POL(M0.hpol), .V_POL(M0.vpol), .CW(10)
  ) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .pix_ce(pc[0]), .sx(sx_w[0]), .sy(sy_w[0]),
    .de(de_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .line_start(ls_w[0]),
    .frame_start(fs_w[0])
  );

  vga_timing_gen #(
    .CLK_DIV(M1.div), .H_ACTIVE(M1.ha), .H_FP(M1.hfp), .H_SYNC(M1.hs), .H_BP(M1.hbp),
    .V_ACTIVE(M1.va), .V_FP(M1.vfp), .V_SYNC(M1.vs), .V_BP(M1.vbp),
    .H_POL(M1.hpol), .V_POL(M1.vpol), .CW(10)
  ) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .pix_ce(pc[1]), .sx(sx_w[1]), .sy(sy_w[1]),
    .de(de_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .line_start(ls_w[1]),
    .frame_start(fs_w[1])
  );

  vga_timing_gen #(
    .CLK_DIV(M2.div), .H_ACTIVE(M2.ha), .H_FP(M2.hfp), .H_SYNC(M2.hs), .H_BP(M2.hbp),
    .V_ACTIVE(M2.va), .V_FP(M2.vfp), .V_SYNC(M2.vs), .V_BP(M2.vbp),
    .H_POL(M2.hpol), .V_POL(M2.vpol), .CW(10)
  ) u_dut2 (
    .clk(clk), .rst(rst), .enable(enable), .pix_ce(pc[2]), .sx(sx_w[2]), .sy(sy_w[2]),
    .de(de_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .line_start(ls_w[2]),
    .frame_start(fs_w[2])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input int inst, input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL u%0d.%s: got %0d, expected %0d (cycle %0d)", inst, tag, got, exp, cyc);
    end
  endtask

  // Reference model state: enabled clocks since reset, pixel ticks since
  // reset, and whether the most recent edge consumed a pixel tick.
  int unsigned e_m   [N];
  int unsigned k_m   [N];
  bit          adv_m [N];

  // A pixel tick is pending once CLK_DIV-1 enabled clocks into each period
  // have elapsed; with CLK_DIV=1 it is pending on every clock after the first.
  function automatic bit tick_of(input int i);
    mode_t m = mode_of(i);
    if (m.div == 1) return e_m[i] >= 1;
    return (e_m[i] % m.div) == (m.div - 1);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        e_m[i] = 0; k_m[i] = 0; adv_m[i] = 1'b0;
      end else if (enable) begin
        adv_m[i] = tick_of(i);
        if (adv_m[i]) k_m[i]++;
        e_m[i]++;
      end else begin
        adv_m[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      mode_t       m  = mode_of(i);
      int unsigned ht = m.ha + m.hfp + m.hs + m.hbp;
      int unsigned vt = m.va + m.vfp + m.vs + m.vbp;
      int unsigned fr = ht * vt;
      // Tick n (1-based) lands on linear index n-1; before any tick the
      // raster rests on the last index of the frame.
      int unsigned li = (k_m[i] == 0) ? fr - 1 : (k_m[i] - 1) % fr;
      int unsigned x  = li % ht;
      int unsigned y  = li / ht;
      bit hs_on = (x >= m.ha + m.hfp) && (x < m.ha + m.hfp + m.hs);
      bit vs_on = (y >= m.va + m.vfp) && (y < m.va + m.vfp + m.vs);
      check(i, "pix_ce", pc[i], enable && tick_of(i));
      check(i, "sx", sx_w[i], x);
      check(i, "sy", sy_w[i], y);
      check(i, "de", de_w[i], (x < m.ha) && (y < m.va));
      check(i, "hsync", hs_w[i], hs_on ? m.hpol : !m.hpol);
      check(i, "vsync", vs_w[i], vs_on ? m.vpol : !m.vpol);
      check(i, "line_start", ls_w[i], enable && adv_m[i] && (x == 0));
      check(i, "frame_start", fs_w[i], enable && adv_m[i] && (x == 0) && (y == 0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  initial begin
    int          lat;
    int          first_ce;
    int          de_c, hs_c, hs2_c, ls_c;
    bit          b_seen;
    int          b_last, b_vs, b_de;
    logic [9:0]  hold_sx, hold_sy;
    int          hold_ce;

    for (int i = 0; i < N; i++) begin
      e_m[i] = 0; k_m[i] = 0; adv_m[i] = 1'b0;
    end

    // Reset, first with enable low, then with enable high (must not run).
    rst = 1'b1; enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    step();
    check(0, "rst_sx", sx_w[0], 799);
    check(0, "rst_sy", sy_w[0], 524);
    check(0, "rst_hsync", hs_w[0], 1);
    check(0, "rst_vsync", vs_w[0], 1);
    check(2, "rst_hsync", hs_w[2], 0);

    // Release: first tick after three enabled clocks, (0,0) on the fourth.
    rst = 1'b0;
    lat = 0; first_ce = 0;
    while (!fs_w[0] && lat < 10) begin
      step();
      lat++;
      if (pc[0] && first_ce == 0) first_ce = lat;
    end
    check(0, "first_ce_clk", first_ce, 3);
    check(0, "first_frame_clk", lat, 4);

    // One full line of the default modes, and many frames of the tiny mode.
    de_c = 0; hs_c = 0; hs2_c = 0; ls_c = 0;
    b_seen = 1'b0; b_last = 0; b_vs = 0; b_de = 0;
    for (int c = 0; c < 3200; c++) begin
      if (c > 0) step();
      de_c  += int'(de_w[0]);
      hs_c  += int'(hs_w[0] == 1'b0);
      hs2_c += int'(hs_w[2] == 1'b1);
      ls_c  += int'(ls_w[0]);
      if (fs_w[1]) begin
        if (b_seen) begin
          check(1, "frame_period", cyc - b_last, 98);
          check(1, "vsync_clks", b_vs, 14);
          check(1, "de_clks", b_de, 32);
        end
        b_seen = 1'b1; b_last = cyc; b_vs = 0; b_de = 0;
      end
      b_vs += int'(vs_w[1] == 1'b0);
      b_de += int'(de_w[1]);
    end
    check(0, "line_de_clks", de_c, 2560);
    check(0, "line_hsync_clks", hs_c, 384);
    check(2, "line_hsync_clks", hs2_c, 384);
    check(0, "line_strobes", ls_c, 1);
    step();
    check(0, "next_line_start", ls_w[0], 1);
    check(0, "next_line_sy", sy_w[0], 1);

    // Freeze mid-line for 50 clocks at an arbitrary divider phase.
    repeat (37 + $urandom_range(0, 3)) step();
    hold_sx = sx_w[0]; hold_sy = sy_w[0];
    enable = 1'b0;
    hold_ce = 0;
    repeat (50) begin
      step();
      hold_ce += int'(pc[0]);
    end
    check(0, "hold_sx", sx_w[0], hold_sx);
    check(0, "hold_sy", sy_w[0], hold_sy);
    check(0, "hold_ce", hold_ce, 0);
    enable = 1'b1;
    repeat (200) step();

    // Randomised enable bursts with occasional mid-run resets.
    for (int r = 0; r < 120; r++) begin
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 120)) step();
      if (r % 25 == 24) begin
        enable = $urandom_range(0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check(0, "midrst_sx", sx_w[0], 799);
        check(0, "midrst_sy", sy_w[0], 524);
        check(0, "midrst_ce", pc[0], 0);
      end
    end

    enable = 1'b1;
    repeat (500) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
